// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: grad = err * act * (1 - act), Q3.5 in and out.
// Three-stage valid/ready pipeline; all stages shift together on adv.
module sigmoid_backprop (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] act,
  input  logic [7:0] err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] grad
);

  logic adv;
  assign adv      = en & (~out_valid | out_ready);
  assign in_ready = adv;

  logic       v1, v2;
  logic [5:0] a1;
  logic [7:0] e1, e2;
  logic [3:0] d2;

  logic [5:0] a_next;
  always_comb begin
    a_next = act[5:0];
    if (act[7])
      a_next = 6'd0;
    else if (act > 8'h20)
      a_next = 6'h20;
  end

  // a*(32-a) peaks at 256 for a = 16, so 9 bits hold the rounded sum
  logic [8:0] prod;
  logic [3:0] d_next;
  always_comb begin
    prod   = {3'b000, a1} * (9'd32 - {3'b000, a1});
    d_next = 4'((prod + 9'd16) >> 5);
  end

  logic signed [12:0] p;
  logic signed [12:0] g_sh;
  logic        [7:0]  g_next;
  always_comb begin
    p    = $signed(e2) * $signed({1'b0, d2});
    g_sh = (p + 13'sd16) >>> 5;
    if (g_sh > 13'sd127)
      g_next = 8'h7F;
    else if (g_sh < -13'sd128)
      g_next = 8'h80;
    else
      g_next = g_sh[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a1        <= '0;
      e1        <= '0;
      e2        <= '0;
      d2        <= '0;
      grad      <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      a1        <= a_next;
      e1        <= err;
      v2        <= v1;
      d2        <= d_next;
      e2        <= e1;
      out_valid <= v2;
      grad      <= g_next;
    end
  end

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Scoreboard bench for sigmoid_backprop: expected grads queued at acceptance,
// compared at output handshake, with latency tracked in advancing cycles.
module tb_sigmoid_backprop;

  logic       clk = 1'b0;
  logic       reset, en, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] act, err, grad;

  sigmoid_backprop dut (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .act(act), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .grad(grad)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];
  int         lat_q[$];
  int         adv_cnt = 0;
  logic       rst_prev = 1'b1;
  logic       hold_prev = 1'b0;
  logic [7:0] saved_grad;
  logic       saved_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a_in, input logic [7:0] e_in);
    int av, d, ev, p, g;
    logic [31:0] gv;
    if (a_in[7]) av = 0;
    else if (a_in > 8'h20) av = 32;
    else av = int'(a_in);
    d  = (av * (32 - av) + 16) / 32;
    ev = int'($signed(e_in));
    p  = ev * d;
    g  = (p + 16) >>> 5;
    if (g > 127) g = 127;
    if (g < -128) g = -128;
    gv = g;
    return gv[7:0];
  endfunction

  task automatic step(input logic rst, input logic e_i, input logic iv,
                      input logic [7:0] a_i, input logic [7:0] er_i, input logic ordy);
    logic [7:0] exp_g;
    @(negedge clk);
    reset = rst; en = e_i; in_valid = iv; act = a_i; err = er_i; out_ready = ordy;
    #1;
    if (rst_prev) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_grad", grad, 0);
    end
    if (hold_prev) begin
      check("hold_grad", grad, saved_grad);
      check("hold_out_valid", out_valid, saved_ov);
    end
    hold_prev = 1'b0;
    if (rst) begin
      sb_q.delete();
      lat_q.delete();
    end else begin
      check("in_ready", in_ready, e_i & (~out_valid | ordy));
      if (e_i && out_valid && ordy) begin
        if (sb_q.size() == 0)
          check("spurious_out", 1, 0);
        else begin
          exp_g = sb_q.pop_front();
          check("grad", grad, exp_g);
          check("latency", adv_cnt, lat_q.pop_front());
        end
      end
      if (iv && in_ready) begin
        sb_q.push_back(model(a_i, er_i));
        lat_q.push_back(adv_cnt + 3);
      end
      if (in_ready) adv_cnt++;
      if (!e_i || (out_valid && !ordy)) begin
        hold_prev  = 1'b1;
        saved_grad = grad;
        saved_ov   = out_valid;
      end
    end
    rst_prev = rst;
  endtask

  logic [7:0] s_act[7] = '{8'h10, 8'h08, 8'h10, 8'h20, 8'h90, 8'h30, 8'h00};
  logic [7:0] s_err[7] = '{8'h20, 8'hE0, 8'h7F, 8'h7F, 8'h40, 8'h40, 8'h5A};
  logic [7:0] s_exp[7] = '{8'h08, 8'hFA, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; act = '0; err = '0; out_ready = 1'b1;
    @(posedge clk);
    step(1, 1, 0, 8'h00, 8'h00, 1);

    // directed vectors: also pin the model against hand-derived results
    for (int i = 0; i < 7; i++) begin
      check("model_vec", model(s_act[i], s_err[i]), s_exp[i]);
      step(0, 1, 1, s_act[i], s_err[i], 1);
    end
    repeat (4) step(0, 1, 0, 8'h00, 8'h00, 1);

    // backpressure: fill three, stall five cycles with input offered, release
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 8'($urandom_range(0, 32)), 8'($urandom), 1);
    repeat (5) step(0, 1, 1, 8'h11, 8'h33, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'h00, 8'h00, 1);
      check("release_valid", out_valid, 1);
    end
    repeat (2) step(0, 1, 0, 8'h00, 8'h00, 1);

    // enable dropped mid-stream with input still offered
    step(0, 1, 1, 8'h0C, 8'h50, 1);
    step(0, 1, 1, 8'h14, 8'hB0, 1);
    repeat (4) step(0, 0, 1, 8'h18, 8'h7F, 0);
    step(0, 1, 1, 8'h18, 8'h7F, 1);
    step(0, 1, 1, 8'h04, 8'h80, 1);
    repeat (5) step(0, 1, 0, 8'h00, 8'h00, 1);

    // random stream with occasional backpressure
    for (int i = 0; i < 40; i++)
      step(0, 1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    repeat (8) step(0, 1, 0, 8'h00, 8'h00, 1);

    // reset with two items in flight: they must never appear
    step(0, 1, 1, 8'h10, 8'h20, 1);
    step(0, 1, 1, 8'h08, 8'h40, 1);
    step(1, 1, 0, 8'h00, 8'h00, 1);
    step(0, 1, 0, 8'h00, 8'h00, 1);
    check("flush_out_valid", out_valid, 0);
    repeat (5) step(0, 1, 0, 8'h00, 8'h00, 1);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
